// File: rtl/cpu_run_ctrl.sv
// Run/debug controller beside the multi-cycle CPU: stretches its reset, gates its progress,
// takes RUN/HALT/STEP commands, halts on PC breakpoints and keeps cycle/instruction counters.
module cpu_run_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int NUM_BP     = 4,
    parameter int BP_IDX_W   = 2,
    parameter int RST_CYCLES = 4,
    parameter bit START_RUN  = 1'b1,
    parameter int CNT_W      = 32
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic                bp_wr_i,
    input  logic [BP_IDX_W-1:0] bp_idx_i,
    input  logic [ADDR_W-1:0]   bp_addr_i,
    input  logic                bp_en_i,
    input  logic                instr_done_i,
    input  logic [ADDR_W-1:0]   pc_next_i,
    output logic                cpu_reset_o,
    output logic                cpu_run_o,
    output logic [1:0]          state_o,
    output logic                halted_bp_o,
    output logic [BP_IDX_W-1:0] bp_hit_idx_o,
    output logic [CNT_W-1:0]    cycle_cnt_o,
    output logic [CNT_W-1:0]    instr_cnt_o
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [1:0] OP_RUN   = 2'b00;
    localparam logic [1:0] OP_HALT  = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_HALT       = 2'd1,
        ST_RUN        = 2'd2,
        ST_STEP       = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic                halt_pend_q, halt_pend_d;
    logic                halted_bp_q, halted_bp_d;
    logic [BP_IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                cpu_run_q, cpu_run_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [CNT_W-1:0]    ins_q, ins_d;

    logic [ADDR_W-1:0]   bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0]   bp_en_q;
    logic [NUM_BP-1:0]   bp_match;
    logic                hit_any;
    logic [BP_IDX_W-1:0] hit_idx;
    logic                cmd_acc;

    // Compare uses the registered table, so a same-cycle write only takes effect next edge.
    generate
        for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_match
            assign bp_match[gi] = bp_en_q[gi] && (bp_addr_q[gi] == pc_next_i);
        end
    endgenerate

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_match[i]) begin
                hit_any = 1'b1;
                hit_idx = BP_IDX_W'(i);
            end
        end
    end

    assign cmd_acc = cmd_valid_i && cmd_ready_q;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        halt_pend_d = halt_pend_q;
        halted_bp_d = halted_bp_q;
        hit_idx_d   = hit_idx_q;
        cyc_d       = cpu_run_q ? cyc_q + CNT_W'(1) : cyc_q;
        ins_d       = (cpu_run_q && instr_done_i) ? ins_q + CNT_W'(1) : ins_q;

        case (state_q)
            ST_RESET_HOLD: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = START_RUN ? ST_RUN : ST_HALT;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            ST_HALT: begin
                if (cmd_acc && (cmd_op_i == OP_RUN)) begin
                    state_d     = ST_RUN;
                    halted_bp_d = 1'b0;
                end else if (cmd_acc && (cmd_op_i == OP_STEP)) begin
                    state_d     = ST_STEP;
                    halted_bp_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (cmd_acc && (cmd_op_i == OP_HALT)) begin
                    halt_pend_d = 1'b1;
                end
                // Halts only land on an instruction boundary; a breakpoint outranks a pending halt.
                if (instr_done_i && hit_any) begin
                    state_d     = ST_HALT;
                    halted_bp_d = 1'b1;
                    hit_idx_d   = hit_idx;
                    halt_pend_d = 1'b0;
                end else if (instr_done_i && halt_pend_q) begin
                    state_d     = ST_HALT;
                    halted_bp_d = 1'b0;
                    halt_pend_d = 1'b0;
                end
            end
            ST_STEP: begin
                if (instr_done_i) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_RESET_HOLD;
        endcase

        if (cmd_acc && (cmd_op_i == OP_CLEAR)) begin
            cyc_d = '0;
            ins_d = '0;
        end

        cpu_reset_d = (state_d != ST_RESET_HOLD);
        cpu_run_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
        cmd_ready_d = ((state_d == ST_HALT) || (state_d == ST_RUN)) && !halt_pend_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_RESET_HOLD;
            rst_cnt_q   <= '0;
            halt_pend_q <= 1'b0;
            halted_bp_q <= 1'b0;
            hit_idx_q   <= '0;
            cpu_reset_q <= 1'b0;
            cpu_run_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= '0;
            ins_q       <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            halt_pend_q <= halt_pend_d;
            halted_bp_q <= halted_bp_d;
            hit_idx_q   <= hit_idx_d;
            cpu_reset_q <= cpu_reset_d;
            cpu_run_q   <= cpu_run_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            ins_q       <= ins_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
                bp_en_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (bp_wr_i && (bp_idx_i == BP_IDX_W'(i))) begin
                    bp_addr_q[i] <= bp_addr_i;
                    bp_en_q[i]   <= bp_en_i;
                end
            end
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign cpu_reset_o  = cpu_reset_q;
    assign cpu_run_o    = cpu_run_q;
    assign state_o      = state_q;
    assign halted_bp_o  = halted_bp_q;
    assign bp_hit_idx_o = hit_idx_q;
    assign cycle_cnt_o  = cyc_q;
    assign instr_cnt_o  = ins_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed vector table, multi-cycle corner sequences and
// randomized traffic against a rule-level reference model.
module tb_cpu_run_ctrl;

    localparam int ADDR_W     = 32;
    localparam int NUM_BP     = 4;
    localparam int BP_IDX_W   = 2;
    localparam int RST_CYCLES = 4;
    localparam bit START_RUN  = 1'b1;
    localparam int CNT_W      = 4;
    localparam int CNT_MOD    = 1 << CNT_W;

    logic                clk_i = 1'b0;
    logic                reset_ni;
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [1:0]          cmd_op_i;
    logic                bp_wr_i;
    logic [BP_IDX_W-1:0] bp_idx_i;
    logic [ADDR_W-1:0]   bp_addr_i;
    logic                bp_en_i;
    logic                instr_done_i;
    logic [ADDR_W-1:0]   pc_next_i;
    logic                cpu_reset_o;
    logic                cpu_run_o;
    logic [1:0]          state_o;
    logic                halted_bp_o;
    logic [BP_IDX_W-1:0] bp_hit_idx_o;
    logic [CNT_W-1:0]    cycle_cnt_o;
    logic [CNT_W-1:0]    instr_cnt_o;

    cpu_run_ctrl #(
        .ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .BP_IDX_W(BP_IDX_W),
        .RST_CYCLES(RST_CYCLES), .START_RUN(START_RUN), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .bp_wr_i(bp_wr_i), .bp_idx_i(bp_idx_i), .bp_addr_i(bp_addr_i), .bp_en_i(bp_en_i),
        .instr_done_i(instr_done_i), .pc_next_i(pc_next_i),
        .cpu_reset_o(cpu_reset_o), .cpu_run_o(cpu_run_o), .state_o(state_o),
        .halted_bp_o(halted_bp_o), .bp_hit_idx_o(bp_hit_idx_o),
        .cycle_cnt_o(cycle_cnt_o), .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: 0 reset-hold, 1 halt, 2 run, 3 step; counters kept as plain integers.
    int          m_state, m_hold, m_idx, m_cyc, m_ins;
    bit          m_pend, m_hb;
    logic [31:0] m_addr [NUM_BP];
    bit          m_en   [NUM_BP];

    function automatic void model_reset();
        m_state = 0; m_hold = 0; m_idx = 0; m_cyc = 0; m_ins = 0;
        m_pend = 0; m_hb = 0;
        for (int i = 0; i < NUM_BP; i++) begin
            m_addr[i] = '0;
            m_en[i]   = 0;
        end
    endfunction

    function automatic void model_edge();
        bit running, ready, acc, pend_before;
        int hit;
        if (!reset_ni) begin
            model_reset();
            return;
        end
        running     = (m_state == 2) || (m_state == 3);
        ready       = ((m_state == 1) || (m_state == 2)) && !m_pend;
        acc         = cmd_valid_i && ready;
        pend_before = m_pend;
        hit = -1;
        for (int i = 0; i < NUM_BP; i++)
            if (hit < 0 && m_en[i] && m_addr[i] == pc_next_i) hit = i;
        if (running) m_cyc = (m_cyc + 1) % CNT_MOD;
        if (running && instr_done_i) m_ins = (m_ins + 1) % CNT_MOD;
        if (acc && cmd_op_i == 2'd3) begin
            m_cyc = 0;
            m_ins = 0;
        end
        case (m_state)
            0: begin
                m_hold++;
                if (m_hold == RST_CYCLES) m_state = START_RUN ? 2 : 1;
            end
            1: begin
                if (acc && (cmd_op_i == 2'd0 || cmd_op_i == 2'd2)) begin
                    m_state = (cmd_op_i == 2'd0) ? 2 : 3;
                    m_hb    = 0;
                end
            end
            2: begin
                if (acc && cmd_op_i == 2'd1) m_pend = 1;
                if (instr_done_i && hit >= 0) begin
                    m_state = 1; m_hb = 1; m_idx = hit; m_pend = 0;
                end else if (instr_done_i && pend_before) begin
                    m_state = 1; m_hb = 0; m_pend = 0;
                end
            end
            default: if (instr_done_i) m_state = 1;
        endcase
        if (bp_wr_i) begin
            m_addr[bp_idx_i] = bp_addr_i;
            m_en[bp_idx_i]   = bp_en_i;
        end
    endfunction

    task automatic check_model();
        chk("m_cpu_reset", 32'(cpu_reset_o), 32'(m_state != 0));
        chk("m_cpu_run",   32'(cpu_run_o),   32'(m_state == 2 || m_state == 3));
        chk("m_state",     32'(state_o),     32'(m_state));
        chk("m_cmd_ready", 32'(cmd_ready_o), 32'((m_state == 1 || m_state == 2) && !m_pend));
        chk("m_halted_bp", 32'(halted_bp_o), 32'(m_hb));
        chk("m_hit_idx",   32'(bp_hit_idx_o), 32'(m_idx));
        chk("m_cycle_cnt", 32'(cycle_cnt_o), 32'(m_cyc));
        chk("m_instr_cnt", 32'(instr_cnt_o), 32'(m_ins));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        model_edge();
        check_model();
    endtask

    task automatic idle_inputs();
        cmd_valid_i = 0; cmd_op_i = 2'd0; bp_wr_i = 0; bp_idx_i = '0;
        bp_addr_i = '0; bp_en_i = 0; instr_done_i = 0; pc_next_i = '0;
    endtask

    typedef struct {
        bit          cv;
        logic [1:0]  op;
        bit          done;
        logic [31:0] pc;
        bit          bw;
        logic [1:0]  bi;
        logic [31:0] ba;
        bit          be;
        int          e_state;
        bit          e_run;
        bit          e_hb;
        int          e_idx;
        int          e_ins;
        bit          e_rdy;
        int          e_cyc;
    } vec_t;

    function automatic vec_t mk(bit cv, logic [1:0] op, bit done, logic [31:0] pc,
                                bit bw, logic [1:0] bi, logic [31:0] ba, bit be,
                                int st, bit run, bit hb, int idx, int ins, bit rdy, int cyc);
        vec_t v;
        v.cv = cv; v.op = op; v.done = done; v.pc = pc;
        v.bw = bw; v.bi = bi; v.ba = ba; v.be = be;
        v.e_state = st; v.e_run = run; v.e_hb = hb; v.e_idx = idx;
        v.e_ins = ins; v.e_rdy = rdy; v.e_cyc = cyc;
        return v;
    endfunction

    vec_t        tbl [30];
    logic [31:0] pcs [4];

    initial begin
        // ops: 0 RUN, 1 HALT, 2 STEP, 3 CLEAR
        tbl[0]  = mk(0,0,0,'h00, 1,0,'h10,1, 2,1,0,0, 0,1,-1);
        tbl[1]  = mk(0,0,1,'h04, 0,0,0,0,    2,1,0,0, 1,1,-1);
        tbl[2]  = mk(0,0,1,'h08, 0,0,0,0,    2,1,0,0, 2,1,-1);
        tbl[3]  = mk(0,0,0,'h00, 0,0,0,0,    2,1,0,0, 2,1,-1);
        tbl[4]  = mk(0,0,1,'h0C, 0,0,0,0,    2,1,0,0, 3,1,-1);
        tbl[5]  = mk(0,0,1,'h10, 0,0,0,0,    1,0,1,0, 4,1,-1);
        tbl[6]  = mk(0,0,1,'h10, 0,0,0,0,    1,0,1,0, 4,1,-1);
        tbl[7]  = mk(1,2,0,'h00, 0,0,0,0,    3,1,0,0, 4,0,-1);
        tbl[8]  = mk(0,0,0,'h00, 0,0,0,0,    3,1,0,0, 4,0,-1);
        tbl[9]  = mk(0,0,1,'h14, 0,0,0,0,    1,0,0,0, 5,1,-1);
        tbl[10] = mk(1,0,0,'h00, 0,0,0,0,    2,1,0,0, 5,1,-1);
        tbl[11] = mk(0,0,1,'h14, 0,0,0,0,    2,1,0,0, 6,1,-1);
        tbl[12] = mk(1,1,0,'h00, 0,0,0,0,    2,1,0,0, 6,0,-1);
        tbl[13] = mk(0,0,0,'h00, 0,0,0,0,    2,1,0,0, 6,0,-1);
        tbl[14] = mk(0,0,0,'h00, 0,0,0,0,    2,1,0,0, 6,0,-1);
        tbl[15] = mk(0,0,1,'h18, 0,0,0,0,    1,0,0,0, 7,1,-1);
        tbl[16] = mk(1,0,0,'h00, 0,0,0,0,    2,1,0,0, 7,1,-1);
        tbl[17] = mk(0,0,0,'h00, 1,1,'h20,1, 2,1,0,0, 7,1,-1);
        tbl[18] = mk(0,0,1,'h1C, 1,3,'h20,1, 2,1,0,0, 8,1,-1);
        tbl[19] = mk(0,0,1,'h20, 0,0,0,0,    1,0,1,1, 9,1,-1);
        tbl[20] = mk(1,0,0,'h00, 0,0,0,0,    2,1,0,1, 9,1,-1);
        tbl[21] = mk(0,0,1,'h24, 1,2,'h24,1, 2,1,0,1, 10,1,-1);
        tbl[22] = mk(1,3,1,'h28, 0,0,0,0,    2,1,0,1, 0,1,0);
        tbl[23] = mk(0,0,0,'h00, 0,0,0,0,    2,1,0,1, 0,1,1);
        tbl[24] = mk(0,0,1,'h24, 0,0,0,0,    1,0,1,2, 1,1,-1);
        tbl[25] = mk(1,0,0,'h00, 0,0,0,0,    2,1,0,2, 1,1,-1);
        tbl[26] = mk(1,1,0,'h00, 0,0,0,0,    2,1,0,2, 1,0,-1);
        tbl[27] = mk(0,0,1,'h10, 0,0,0,0,    1,0,1,0, 2,1,-1);
        tbl[28] = mk(1,3,0,'h00, 0,0,0,0,    1,0,1,0, 0,1,0);
        tbl[29] = mk(1,0,0,'h00, 0,0,0,0,    2,1,0,0, 0,1,0);
        pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h20; pcs[3] = 32'h24;

        idle_inputs();
        reset_ni = 1'b1;
        #1 reset_ni = 1'b0;
        model_reset();
        #1;
        chk("rst_state",     32'(state_o),     32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset_o), 32'd0);
        chk("rst_cpu_run",   32'(cpu_run_o),   32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_counters",  32'({cycle_cnt_o, instr_cnt_o}), 32'd0);
        tick();
        tick();
        #8 reset_ni = 1'b1;
        for (int i = 1; i <= RST_CYCLES; i++) begin
            tick();
            chk("hold_state",     32'(state_o),     (i == RST_CYCLES) ? 32'd2 : 32'd0);
            chk("hold_cpu_reset", 32'(cpu_reset_o), 32'(i == RST_CYCLES));
            chk("hold_cpu_run",   32'(cpu_run_o),   32'(i == RST_CYCLES));
        end

        for (int i = 0; i < 30; i++) begin
            cmd_valid_i = tbl[i].cv;  cmd_op_i  = tbl[i].op;
            instr_done_i = tbl[i].done; pc_next_i = tbl[i].pc;
            bp_wr_i = tbl[i].bw; bp_idx_i = tbl[i].bi; bp_addr_i = tbl[i].ba; bp_en_i = tbl[i].be;
            tick();
            chk("vec_state",     32'(state_o),      32'(tbl[i].e_state));
            chk("vec_cpu_run",   32'(cpu_run_o),    32'(tbl[i].e_run));
            chk("vec_halted_bp", 32'(halted_bp_o),  32'(tbl[i].e_hb));
            chk("vec_hit_idx",   32'(bp_hit_idx_o), 32'(tbl[i].e_idx));
            chk("vec_instr_cnt", 32'(instr_cnt_o),  32'(tbl[i].e_ins));
            chk("vec_cmd_ready", 32'(cmd_ready_o),  32'(tbl[i].e_rdy));
            if (tbl[i].e_cyc >= 0) chk("vec_cycle_cnt", 32'(cycle_cnt_o), 32'(tbl[i].e_cyc));
            $display("vec %0d state=%0d run=%0b hb=%0b idx=%0d ins=%0d cyc=%0d",
                     i, state_o, cpu_run_o, halted_bp_o, bp_hit_idx_o, instr_cnt_o, cycle_cnt_o);
        end
        idle_inputs();

        repeat (17) tick();
        chk("wrap_cycle_cnt", 32'(cycle_cnt_o), 32'd1);
        $display("wrap cycle_cnt=%0d after 17 running cycles", cycle_cnt_o);

        #1 reset_ni = 1'b0;
        #1;
        model_reset();
        chk("midrst_cpu_reset", 32'(cpu_reset_o), 32'd0);
        chk("midrst_cpu_run",   32'(cpu_run_o),   32'd0);
        chk("midrst_state",     32'(state_o),     32'd0);
        chk("midrst_counters",  32'({cycle_cnt_o, instr_cnt_o}), 32'd0);
        tick();
        #3 reset_ni = 1'b1;
        repeat (RST_CYCLES) tick();
        instr_done_i = 1; pc_next_i = 32'h10;
        tick();
        chk("bp_cleared_state", 32'(state_o), 32'd2);
        $display("mid-run reset recovered state=%0d", state_o);
        idle_inputs();

        for (int n = 0; n < 3000; n++) begin
            cmd_valid_i  = ($urandom_range(0, 3) == 0);
            cmd_op_i     = ($urandom_range(0, 4) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            instr_done_i = ($urandom_range(0, 2) == 0);
            pc_next_i    = pcs[$urandom_range(0, 3)];
            bp_wr_i      = ($urandom_range(0, 7) == 0);
            bp_idx_i     = 2'($urandom_range(0, 3));
            bp_addr_i    = pcs[$urandom_range(0, 3)];
            bp_en_i      = 1'($urandom_range(0, 1));
            tick();
            if ($urandom_range(0, 399) == 0) begin
                reset_ni = 1'b0;
                #1;
                model_reset();
                check_model();
                tick();
                #3 reset_ni = 1'b1;
            end
        end
        $display("random phase done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
